wb_camera_capture: RTL and testbench
====================================

# wb_camera_capture

Parametrised Wishbone slave that captures one parallel-bus camera frame (OV7670-style PCLK/VSYNC/HREF/D[7:0]) into an on-chip frame buffer and exposes it to the CPU. It is the next generation of the single-mode camera peripheral and adds:

- configurable resolution and 1- or 2-byte pixels;
- continuous capture mode, overflow detection, a frame counter and an interrupt.

It sits on the SoC Wishbone bus beside the UART/GPIO slaves. All camera inputs are oversampled in the system clock domain.

## Interface
Parameters:
- H_RES, 160, pixels per line.
- V_RES, 120, lines per frame. H_RES*V_RES ≤ 16384.
- BYTES_PER_PIXEL, 2, 1 (8-bit gray) or 2 (RGB565, first byte = high byte).
- XCLK_DIV, 4, even value ≥ 2. camera_xclk = clk / XCLK_DIV.

Ports:
- clk  in  1  system clock; all logic is clocked on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- wb_stb_i, wb_cyc_i, wb_we_i  in  1  Wishbone strobe, cycle and write enable.
- wb_adr_i  in  32  byte address.
- wb_sel_i  in  4  byte selects; ignored, all accesses are treated as 32-bit.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data, registered.
- wb_ack_o  out  1  acknowledge.
- camera_xclk  out  1  camera master clock.
- camera_pclk, camera_vsync, camera_href  in  1  camera timing.
- camera_data  in  8  camera pixel byte.
- irq  out  1  frame-done interrupt; irq = done & irq_en.

## Operation
Register map. Only wb_adr_i[16] and wb_adr_i[15:2] are decoded.
- 0x00 STATUS
  - Read: bit0 done, bit1 busy, bit2 overflow, [31:16] frame_count.
  - Write: 1s in bit0 and bit2 clear those bits (W1C).
- 0x04 CTRL, read/write.
  - bit0 start: write-only, self-clearing, reads 0.
  - bit1 continuous.
  - bit2 irq_en.
  - bit3 abort: write-only, reads 0.
- 0x08 SIZE, read-only: {V_RES[15:0], H_RES[15:0]}.
- 0x0C PIXCOUNT, read-only: pixels stored in the last completed frame.
- 0x10000 + 4n FRAME: pixel n, zero-extended.
  - Index n ≥ H_RES*V_RES reads 0.
  - Writes are acked and have no effect.
- Any other address reads 0; writes are acked and ignored.

Input conditioning:
- Two-flop synchronisers on pclk, vsync and href. Data is registered in step with pclk.
- pclk_rise = synced pclk 0→1. vsync_rise and vsync_fall are detected the same way.

Capture FSM:
- IDLE: waits for start=1. On entry to WAIT_VSYNC it clears done, overflow and the write pointer.
- WAIT_VSYNC → CAPTURE on vsync_fall. The write pointer and byte phase reset to 0.
- CAPTURE:
  - On pclk_rise with href=1, the byte is accepted.
  - With BYTES_PER_PIXEL=2, phase 0 latches the high byte and phase 1 writes {hi, lo}. With 1, every byte writes.
  - The byte phase resets at each href rising edge.
  - A write at pointer ≥ H_RES*V_RES is dropped and sets overflow; the pointer saturates.
  - On vsync_rise: done=1, frame_count+1 (wraps 0xFFFF→0), PIXCOUNT = pointer.
  - Next state is WAIT_VSYNC if continuous=1, otherwise IDLE.
- busy = state ≠ IDLE.
- Abort in any state → IDLE. Abort leaves done and frame_count unchanged.
- Start while busy is ignored.
- A start in the same cycle as a vsync edge while IDLE: start wins, and the edge is not used.

## Timing
- Reset values:
  - wb_ack_o = 0, wb_dat_o = 0, irq = 0, camera_xclk = 0.
  - FSM in IDLE; all status and ctrl bits 0; frame_count = 0; PIXCOUNT = 0.
  - Frame buffer contents are not reset.
- Wishbone:
  - The internal ack register is set one cycle after stb&cyc, and is never set two cycles in a row.
  - wb_ack_o = stb & cyc & ack.
  - Every access takes 2 cycles. Read data is valid in the ack cycle, including synchronous RAM reads.
- Capture latency: a camera_data byte reaches the RAM ≤ 4 clk cycles after the pclk edge that presents it. clk must be ≥ 4× pclk.
- A buffer write and a Wishbone read of the same index in the same cycle return the old data.
- done and irq assert in the cycle after vsync_rise is detected.
- camera_xclk toggles every XCLK_DIV/2 cycles, free-running from reset release.

## Configuration
- CAMERA_TEST_PATTERN_EN defined:
  - CTRL bit4 pattern is readable and writable.
  - When pattern=1, stored pixels are the write-pointer value truncated to the pixel width, in place of camera_data.
  - Timing is still driven by href and pclk.
- CAMERA_TEST_PATTERN_EN undefined: bit4 reads 0 and writes to it are ignored.

## Test plan
- Reset mid-capture, with reset asserted asynchronously between clk edges → all outputs take their reset values immediately; STATUS reads 0x00000000 after release.
- Single frame:
  - Setup: H_RES=4, V_RES=2, BPP=2, CTRL=0x1.
  - Stimulus: vsync 1→0, then 2 lines of 8 bytes 0x00..0x0F, then vsync 0→1.
  - Expect: STATUS=0x00010001, PIXCOUNT=8, FRAME[0]=0x0001, FRAME[7]=0x0E0F.
- Overflow (same setup): 3 lines of 8 bytes → STATUS bit2=1, PIXCOUNT=8, FRAME[7] holds line-2 data.
- Continuous with interrupt:
  - Setup: CTRL=0x7, 3 frames.
  - Expect: frame_count=3; irq rises after frame 1.
  - Writing 0x1 to STATUS drops irq within 2 cycles. busy stays 1.
- Abort and contention: abort mid-line → busy=0 next cycle, done unchanged. start in the same cycle as vsync_fall while IDLE → capture begins on the following vsync_fall.
- With CAMERA_TEST_PATTERN_EN and CTRL=0x11, one frame → FRAME[n]=n for n=0..7.

Source files
------------

// File: rtl/wb_camera_capture.sv
// Wishbone slave that captures one OV7670-style parallel camera frame into on-chip RAM.
// Optional build macro CAMERA_TEST_PATTERN_EN enables the CTRL[4] synthetic pattern mode.
module wb_camera_capture #(
  parameter int H_RES           = 160,
  parameter int V_RES           = 120,
  parameter int BYTES_PER_PIXEL = 2,
  parameter int XCLK_DIV        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        camera_xclk,
  input  logic        camera_pclk,
  input  logic        camera_vsync,
  input  logic        camera_href,
  input  logic [7:0]  camera_data,
  output logic        irq
);

  localparam int NPIX  = H_RES * V_RES;
  localparam int PIX_W = 8 * BYTES_PER_PIXEL;
  localparam int AW    = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int PTR_W = $clog2(NPIX + 1);
  localparam int XHALF = XCLK_DIV / 2;
  localparam logic [PTR_W-1:0] NPIX_P = PTR_W'(NPIX);
  localparam logic [14:0] NPIX_A = 15'(NPIX);
  localparam logic TWO_BYTE = (BYTES_PER_PIXEL == 2);
`ifdef CAMERA_TEST_PATTERN_EN
  localparam logic PATTERN_EN = 1'b1;
`else
  localparam logic PATTERN_EN = 1'b0;
`endif

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_CAPTURE = 2'd2} state_t;

  state_t           state_r;
  logic             pclk_s1_r, pclk_s2_r, pclk_s3_r;
  logic             vsync_s1_r, vsync_s2_r, vsync_s3_r;
  logic             href_s1_r, href_s2_r, href_s3_r;
  logic [7:0]       data_s1_r, data_s2_r;
  logic [PTR_W-1:0] ptr_r, pixcount_r;
  logic             phase_r, overflow_r, done_r, irq_r;
  logic [7:0]       hi_r;
  logic             wr_en_r;
  logic [AW-1:0]    wr_addr_r;
  logic [PIX_W-1:0] wr_data_r, ram_q_r;
  logic [15:0]      frame_count_r, xcnt_r;
  logic             continuous_r, irq_en_r, pattern_r, xclk_r;
  logic             ack_r, frame_rd_r;
  logic [31:0]      reg_q_r, reg_rd_s;
  logic [PIX_W-1:0] mem [0:NPIX-1];

  logic pclk_rise_s, vsync_rise_s, vsync_fall_s, href_rise_s;
  logic wb_req_s, wb_wr_s, status_wr_s, ctrl_wr_s, abort_s, start_go_s, frame_end_s;
  logic busy_s, byte_ok_s, phase_eff_s, pix_done_s, done_nxt_s, irq_en_nxt_s;
  logic [13:0]   reg_idx_s;
  logic [14:0]   rd_idx_s;
  logic [AW-1:0] rd_addr_s;
  logic          rd_in_s;
  logic [15:0]   pixel_s;
  logic          unused_s;

  assign unused_s     = ^{wb_sel_i, wb_adr_i[31:17], wb_adr_i[1:0]};
  assign pclk_rise_s  = pclk_s2_r & ~pclk_s3_r;
  assign vsync_rise_s = vsync_s2_r & ~vsync_s3_r;
  assign vsync_fall_s = ~vsync_s2_r & vsync_s3_r;
  assign href_rise_s  = href_s2_r & ~href_s3_r;

  assign wb_req_s    = wb_stb_i & wb_cyc_i & ~ack_r;
  assign wb_wr_s     = wb_req_s & wb_we_i;
  assign reg_idx_s   = wb_adr_i[15:2];
  assign status_wr_s = wb_wr_s & ~wb_adr_i[16] & (reg_idx_s == 14'd0);
  assign ctrl_wr_s   = wb_wr_s & ~wb_adr_i[16] & (reg_idx_s == 14'd1);
  assign abort_s     = ctrl_wr_s & wb_dat_i[3];
  assign start_go_s  = ctrl_wr_s & wb_dat_i[0] & ~wb_dat_i[3] & (state_r == ST_IDLE);
  assign frame_end_s = (state_r == ST_CAPTURE) & vsync_rise_s & ~abort_s;
  assign busy_s      = (state_r != ST_IDLE);
  assign rd_idx_s    = {1'b0, wb_adr_i[15:2]};
  assign rd_addr_s   = AW'(rd_idx_s);
  assign rd_in_s     = (rd_idx_s < NPIX_A);

  // Byte phase restarts on every href rising edge, even if a byte arrives in that cycle.
  assign byte_ok_s   = pclk_rise_s & href_s2_r;
  assign phase_eff_s = href_rise_s ? 1'b0 : phase_r;
  assign pix_done_s  = ~TWO_BYTE | phase_eff_s;

  assign wb_ack_o    = wb_stb_i & wb_cyc_i & ack_r;
  assign wb_dat_o    = frame_rd_r ? 32'(ram_q_r) : reg_q_r;
  assign irq         = irq_r;
  assign camera_xclk = xclk_r;

  // Pixel word selection: synthetic pointer pattern or captured bytes.
  always_comb begin
    if (pattern_r) begin
      pixel_s = 16'(ptr_r);
    end else if (TWO_BYTE) begin
      pixel_s = {hi_r, data_s2_r};
    end else begin
      pixel_s = {8'h00, data_s2_r};
    end
  end

  // Next done / irq_en; a frame end wins over a same-cycle W1C so no event is lost.
  always_comb begin
    if (start_go_s) begin
      done_nxt_s = 1'b0;
    end else if (frame_end_s) begin
      done_nxt_s = 1'b1;
    end else if (status_wr_s && wb_dat_i[0]) begin
      done_nxt_s = 1'b0;
    end else begin
      done_nxt_s = done_r;
    end
    if (ctrl_wr_s) begin
      irq_en_nxt_s = wb_dat_i[2];
    end else begin
      irq_en_nxt_s = irq_en_r;
    end
  end

  // Register read mux.
  always_comb begin
    case (reg_idx_s)
      14'd0:   reg_rd_s = {frame_count_r, 13'd0, overflow_r, busy_s, done_r};
      14'd1:   reg_rd_s = {27'd0, pattern_r, 1'b0, irq_en_r, continuous_r, 1'b0};
      14'd2:   reg_rd_s = {16'(V_RES), 16'(H_RES)};
      14'd3:   reg_rd_s = 32'(pixcount_r);
      default: reg_rd_s = 32'd0;
    endcase
  end

  // Two-flop synchronisers plus an edge-detect stage; data is delayed to stay aligned with pclk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {pclk_s1_r, pclk_s2_r, pclk_s3_r}    <= 3'b000;
      {vsync_s1_r, vsync_s2_r, vsync_s3_r} <= 3'b000;
      {href_s1_r, href_s2_r, href_s3_r}    <= 3'b000;
      data_s1_r <= 8'h00;
      data_s2_r <= 8'h00;
    end else begin
      {pclk_s1_r, pclk_s2_r, pclk_s3_r}    <= {camera_pclk, pclk_s1_r, pclk_s2_r};
      {vsync_s1_r, vsync_s2_r, vsync_s3_r} <= {camera_vsync, vsync_s1_r, vsync_s2_r};
      {href_s1_r, href_s2_r, href_s3_r}    <= {camera_href, href_s1_r, href_s2_r};
      data_s1_r <= camera_data;
      data_s2_r <= data_s1_r;
    end
  end

  // Capture FSM and frame bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      ptr_r         <= '0;
      pixcount_r    <= '0;
      phase_r       <= 1'b0;
      hi_r          <= 8'h00;
      wr_en_r       <= 1'b0;
      wr_addr_r     <= '0;
      wr_data_r     <= '0;
      overflow_r    <= 1'b0;
      frame_count_r <= 16'd0;
    end else begin
      wr_en_r <= 1'b0;
      if (href_rise_s) phase_r <= 1'b0;
      if (status_wr_s && wb_dat_i[2]) overflow_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_go_s) begin
            state_r    <= ST_WAIT;
            ptr_r      <= '0;
            overflow_r <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (abort_s) begin
            state_r <= ST_IDLE;
          end else if (vsync_fall_s) begin
            state_r <= ST_CAPTURE;
            ptr_r   <= '0;
            phase_r <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          if (abort_s) begin
            state_r <= ST_IDLE;
          end else if (vsync_rise_s) begin
            frame_count_r <= frame_count_r + 16'd1;
            pixcount_r    <= ptr_r;
            state_r       <= continuous_r ? ST_WAIT : ST_IDLE;
          end else if (byte_ok_s) begin
            if (pix_done_s) begin
              phase_r <= 1'b0;
              if (ptr_r < NPIX_P) begin
                wr_en_r   <= 1'b1;
                wr_addr_r <= AW'(ptr_r);
                wr_data_r <= pixel_s[PIX_W-1:0];
                ptr_r     <= ptr_r + PTR_W'(1);
              end else begin
                overflow_r <= 1'b1;
              end
            end else begin
              hi_r    <= data_s2_r;
              phase_r <= 1'b1;
            end
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // CTRL bits, done flag and the registered interrupt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      continuous_r <= 1'b0;
      pattern_r    <= 1'b0;
      irq_en_r     <= 1'b0;
      done_r       <= 1'b0;
      irq_r        <= 1'b0;
    end else begin
      if (ctrl_wr_s) begin
        continuous_r <= wb_dat_i[1];
        pattern_r    <= wb_dat_i[4] & PATTERN_EN;
      end
      irq_en_r <= irq_en_nxt_s;
      done_r   <= done_nxt_s;
      irq_r    <= done_nxt_s & irq_en_nxt_s;
    end
  end

  // Wishbone handshake and registered read data; reads are captured in the request cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_r      <= 1'b0;
      frame_rd_r <= 1'b0;
      reg_q_r    <= 32'd0;
    end else begin
      ack_r <= wb_stb_i & wb_cyc_i & ~ack_r;
      if (wb_req_s) begin
        frame_rd_r <= wb_adr_i[16] & rd_in_s;
        reg_q_r    <= wb_adr_i[16] ? 32'd0 : reg_rd_s;
      end
    end
  end

  // Frame buffer: one write port, one synchronous read port with read-old-data behaviour.
  always_ff @(posedge clk) begin
    if (wr_en_r) mem[wr_addr_r] <= wr_data_r;
    ram_q_r <= mem[rd_addr_s];
  end

  // Free-running camera master clock divider.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xcnt_r <= 16'd0;
      xclk_r <= 1'b0;
    end else if (xcnt_r == 16'(XHALF - 1)) begin
      xcnt_r <= 16'd0;
      xclk_r <= ~xclk_r;
    end else begin
      xcnt_r <= xcnt_r + 16'd1;
    end
  end

endmodule

// File: tb/tb_wb_camera_capture.sv
// Self-checking bench for wb_camera_capture (4x2 frame, 2-byte pixels), scoreboard on frame contents.
module tb_wb_camera_capture;
  localparam int NPIX = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_stb_i, wb_cyc_i, wb_we_i;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_ack_o, camera_xclk, irq;
  logic        camera_pclk, camera_vsync, camera_href;
  logic [7:0]  camera_data;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  wb_camera_capture #(.H_RES(4), .V_RES(2), .BYTES_PER_PIXEL(2), .XCLK_DIV(4)) dut (
    .clk(clk), .reset(reset),
    .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .camera_xclk(camera_xclk),
    .camera_pclk(camera_pclk), .camera_vsync(camera_vsync), .camera_href(camera_href),
    .camera_data(camera_data), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    bit got = 1'b0;
    @(posedge clk); #1;
    wb_adr_i = a; wb_dat_i = d; wb_we_i = 1'b1; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (wb_ack_o) begin got = 1'b1; break; end
    end
    @(posedge clk); #1;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL wb_write_ack addr=%h: no ack within 8 cycles", a);
    end
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    bit got = 1'b0;
    d = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    wb_adr_i = a; wb_we_i = 1'b0; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (wb_ack_o) begin got = 1'b1; d = wb_dat_o; break; end
    end
    @(posedge clk); #1;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL wb_read_ack addr=%h: no ack within 8 cycles", a);
    end
  endtask

  task automatic cam_byte(input logic [7:0] b);
    camera_data = b; #40;
    camera_pclk = 1'b1; #40;
    camera_pclk = 1'b0;
  endtask

  task automatic cam_line(input logic [7:0] base);
    camera_href = 1'b1;
    for (int k = 0; k < 8; k++) cam_byte(base + 8'(k));
    #20 camera_href = 1'b0;
    #100;
  endtask

  // One frame of 'lines' lines of 8 bytes; expected pixels are queued as each line is driven.
  task automatic cam_frame(input logic [7:0] base, input int lines, input bit push, input bit pat);
    int idx = 0;
    logic [7:0] b0, b1;
    camera_vsync = 1'b0; #200;
    for (int l = 0; l < lines; l++) begin
      for (int j = 0; j < 4; j++) begin
        b0 = base + 8'(l * 8 + 2 * j);
        b1 = b0 + 8'd1;
        if (push && idx < NPIX) exp_q.push_back(pat ? 32'(idx) : {16'h0000, b0, b1});
        idx++;
      end
      cam_line(base + 8'(l * 8));
    end
    camera_vsync = 1'b1; #200;
  endtask

  task automatic check_frame(input string name);
    logic [31:0] d, e;
    for (int n = 0; n < NPIX; n++) begin
      wb_read(32'h0001_0000 + 32'(n * 4), d);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s_frame[%0d]: scoreboard empty, got %h", name, n, d);
      end else begin
        e = exp_q.pop_front();
        if (d !== e) begin
          errors++;
          $display("FAIL %s_frame[%0d]: got %h expected %h", name, n, d, e);
        end
      end
    end
  endtask

  task automatic check_reg(input string name, input logic [31:0] a, input logic [31:0] e);
    logic [31:0] d;
    wb_read(a, d);
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, d, e);
    end
  endtask

  task automatic test_reset();
    logic exp_x;
    reset = 1'b0;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0; wb_adr_i = 32'd0; wb_dat_i = 32'd0;
    wb_sel_i = 4'hF; camera_pclk = 1'b0; camera_vsync = 1'b1; camera_href = 1'b0;
    camera_data = 8'h00;
    #23;
    checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b expected 0", wb_ack_o); end
    checks++; if (wb_dat_o !== 32'd0) begin errors++; $display("FAIL rst_dat: got %h expected 0", wb_dat_o); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b expected 0", irq); end
    checks++; if (camera_xclk !== 1'b0) begin errors++; $display("FAIL rst_xclk: got %b expected 0", camera_xclk); end
    @(negedge clk); reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      exp_x = ((k / 2) % 2) == 1;
      checks++;
      if (camera_xclk !== exp_x) begin
        errors++;
        $display("FAIL xclk_div cycle %0d: got %b expected %b", k, camera_xclk, exp_x);
      end
    end
    check_reg("rst_status", 32'h0, 32'h0000_0000);
    check_reg("rst_ctrl", 32'h4, 32'h0000_0000);
    check_reg("rst_pixcount", 32'hC, 32'h0000_0000);
    check_reg("size", 32'h8, 32'h0002_0004);
  endtask

  task automatic test_single_frame();
    wb_write(32'h4, 32'h1);
    cam_frame(8'h00, 2, 1'b1, 1'b0);
    check_reg("single_status", 32'h0, 32'h0001_0001);
    check_reg("single_pixcount", 32'hC, 32'h0000_0008);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL single_irq: got %b expected 0", irq); end
    check_frame("single");
  endtask

  task automatic test_overflow();
    wb_write(32'h4, 32'h1);
    cam_frame(8'h00, 3, 1'b1, 1'b0);
    check_reg("ovf_status", 32'h0, 32'h0002_0005);
    check_reg("ovf_pixcount", 32'hC, 32'h0000_0008);
    check_frame("ovf");
    check_reg("frame_oob", 32'h0001_0020, 32'h0000_0000);
    check_reg("unmapped", 32'h0000_0020, 32'h0000_0000);
    wb_write(32'h0001_0000, 32'h0000_FFFF);
    check_reg("frame_write_ignored", 32'h0001_0000, 32'h0000_0001);
    wb_write(32'h0, 32'h5);
    check_reg("ovf_w1c", 32'h0, 32'h0002_0000);
  endtask

  task automatic test_continuous();
    wb_write(32'h4, 32'h7);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL cont_irq_idle: got %b expected 0", irq); end
    cam_frame(8'h20, 2, 1'b0, 1'b0);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL cont_irq_frame1: got %b expected 1", irq); end
    cam_frame(8'h40, 2, 1'b0, 1'b0);
    cam_frame(8'h60, 2, 1'b1, 1'b0);
    check_reg("cont_status", 32'h0, 32'h0005_0003);
    check_frame("cont");
    wb_write(32'h0, 32'h1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL cont_irq_clear: got %b expected 0", irq); end
    check_reg("cont_status_clr", 32'h0, 32'h0005_0002);
    cam_frame(8'h80, 2, 1'b0, 1'b0);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL cont_irq_frame4: got %b expected 1", irq); end
    check_reg("cont_status4", 32'h0, 32'h0006_0003);
    // Partial frame, then asynchronous reset between clock edges.
    camera_vsync = 1'b0; #200;
    camera_href = 1'b1;
    for (int k = 0; k < 3; k++) cam_byte(8'hC0 + 8'(k));
    @(posedge clk); #3; reset = 1'b0; #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL midrst_irq: got %b expected 0", irq); end
    checks++; if (wb_dat_o !== 32'd0) begin errors++; $display("FAIL midrst_dat: got %h expected 0", wb_dat_o); end
    checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL midrst_ack: got %b expected 0", wb_ack_o); end
    checks++; if (camera_xclk !== 1'b0) begin errors++; $display("FAIL midrst_xclk: got %b expected 0", camera_xclk); end
    camera_href = 1'b0; camera_vsync = 1'b1; #100;
    @(negedge clk); reset = 1'b1;
    check_reg("midrst_status", 32'h0, 32'h0000_0000);
    check_reg("midrst_pixcount", 32'hC, 32'h0000_0000);
  endtask

  task automatic test_abort();
    wb_write(32'h4, 32'h3);
    cam_frame(8'h10, 2, 1'b0, 1'b0);
    check_reg("abort_pre_status", 32'h0, 32'h0001_0003);
    camera_vsync = 1'b0; #200;
    fork
      cam_line(8'h40);
      begin #300; wb_write(32'h4, 32'h8); end
    join
    check_reg("abort_status", 32'h0, 32'h0001_0001);
    camera_vsync = 1'b1; #200;
    check_reg("abort_status_after", 32'h0, 32'h0001_0001);
    check_reg("abort_pixcount", 32'hC, 32'h0000_0008);
  endtask

  task automatic test_contention();
    @(posedge clk); #1; camera_vsync = 1'b0;
    @(posedge clk);
    wb_write(32'h4, 32'h1);
    cam_line(8'h55);
    camera_vsync = 1'b1; #200;
    check_reg("contend_status", 32'h0, 32'h0001_0002);
    cam_frame(8'hA0, 2, 1'b1, 1'b0);
    check_reg("contend_status_done", 32'h0, 32'h0002_0001);
    check_reg("contend_pixcount", 32'hC, 32'h0000_0008);
    check_frame("contend");
  endtask

  task automatic test_ctrl_pattern();
`ifdef CAMERA_TEST_PATTERN_EN
    wb_write(32'h4, 32'h11);
    check_reg("pattern_ctrl", 32'h4, 32'h0000_0010);
    cam_frame(8'h00, 2, 1'b1, 1'b1);
    check_reg("pattern_status", 32'h0, 32'h0003_0001);
    check_frame("pattern");
`else
    wb_write(32'h4, 32'h16);
    check_reg("ctrl_rw", 32'h4, 32'h0000_0006);
    wb_write(32'h4, 32'h0);
    check_reg("ctrl_clear", 32'h4, 32'h0000_0000);
`endif
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_overflow();
    test_continuous();
    test_abort();
    test_contention();
    test_ctrl_pattern();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
